// File: rtl/cpu_control_unit.sv
// Instruction-sequencing FSM: fetches a 16-bit word over imem req/ack, decodes it, drives the PC controls and the ALU start/done handshake.
// Shortest fetch is 3 cycles (FETCH, WAIT_MEM, DECODE). run only gates leaving FETCH; a missing imem_ack ends in a sticky fault and HALT.
module cpu_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        pc_en,
    output logic        pc_ld_en,
    output logic [7:0]  pc_ld,
    output logic [15:0] ir,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        illegal,
    output logic        fault,
    output logic        halted
);

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_DECODE   = 3'd2,
        S_EXECUTE  = 3'd3,
        S_WAIT_ALU = 3'd4,
        S_HALT     = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic [3:0]  op;
    logic        op_alu;
    logic        op_illegal;
    logic        op_hlt;
    logic        take_branch;

    assign op = ir_q[15:12];

    // Flags are consumed combinationally, so they are sampled in the DECODE cycle itself.
    always_comb begin
        op_alu      = 1'b0;
        op_illegal  = 1'b0;
        op_hlt      = 1'b0;
        take_branch = 1'b0;
        case (op)
            OP_NOP:                            ;
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7:                  op_alu      = 1'b1;
            OP_JMP:                            take_branch = 1'b1;
            OP_JZ:                             take_branch = flag_z;
            OP_JC:                             take_branch = flag_c;
            OP_HLT:                            op_hlt      = 1'b1;
            default:                           op_illegal  = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            cnt_q   <= 8'h00;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    cnt_d   = 8'h00;
                    state_d = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (cnt_q == TIMEOUT_W) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            S_DECODE: begin
                if (op_alu) begin
                    state_d = S_EXECUTE;
                end else if (op_hlt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_d = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                if (alu_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        pc_en     = 1'b0;
        pc_ld_en  = 1'b0;
        pc_ld     = 8'h00;
        alu_op    = 4'h0;
        alu_start = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_WAIT_MEM: begin
                imem_req = 1'b1;
            end
            S_DECODE: begin
                if (take_branch) begin
                    pc_ld_en = 1'b1;
                    pc_ld    = ir_q[7:0];
                end else if (!op_hlt) begin
                    pc_en   = 1'b1;
                    illegal = op_illegal;
                end
            end
            S_EXECUTE: begin
                alu_start = 1'b1;
                alu_op    = op;
            end
            S_WAIT_ALU: begin
                alu_op = op;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir    = ir_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction table plus hand sequences for timeout, HALT and mid-op reset.
// DECODE strobes are checked from a scoreboard queue filled when the instruction word is acked.
module tb_cpu_control_unit;

    localparam int MEM_TIMEOUT = 15;
    localparam int NXT_FETCH = 0;
    localparam int NXT_ALU   = 1;
    localparam int NXT_HALT  = 2;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        alu_done = 1'b0;
    logic        flag_z = 1'b0;
    logic        flag_c = 1'b0;
    logic        imem_req, pc_en, pc_ld_en, alu_start, illegal, fault, halted;
    logic [7:0]  pc_ld;
    logic [15:0] ir;
    logic [3:0]  alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cpu_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .pc_en(pc_en), .pc_ld_en(pc_ld_en), .pc_ld(pc_ld), .ir(ir),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal),
        .fault(fault), .halted(halted)
    );

    typedef struct {
        logic        e_pc_en;
        logic        e_ld_en;
        logic [7:0]  e_ld;
        logic        e_ill;
        logic [15:0] e_ir;
    } dec_exp_t;

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        c;
        int          ack_dly;
        int          alu_dly;
        logic        e_pc_en;
        logic        e_ld_en;
        logic [7:0]  e_ld;
        logic        e_ill;
        int          nxt;
    } vec_t;

    dec_exp_t exp_q[$];
    vec_t     vt[13];
    logic     dec_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DECODE is the cycle after an accepted imem handshake; every other cycle must be strobe-free.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            dec_next <= 1'b0;
        end else begin
            if (dec_next) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got DECODE with no expectation (t=%0t)", $time);
                end else begin
                    chk("dec_pc_en",    32'(pc_en),    32'(exp_q[0].e_pc_en));
                    chk("dec_pc_ld_en", 32'(pc_ld_en), 32'(exp_q[0].e_ld_en));
                    chk("dec_illegal",  32'(illegal),  32'(exp_q[0].e_ill));
                    chk("dec_ir",       32'(ir),       32'(exp_q[0].e_ir));
                    if (exp_q[0].e_ld_en) chk("dec_pc_ld", 32'(pc_ld), 32'(exp_q[0].e_ld));
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_strobes", 32'({pc_en, pc_ld_en, illegal, pc_ld}), 0);
            end
            dec_next <= imem_req && imem_ack;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({imem_req, pc_en, pc_ld_en, alu_start, illegal, fault, halted}), 0);
        chk({tag, "_ir"},     32'(ir), 0);
        chk({tag, "_alu_op"}, 32'(alu_op), 0);
        chk({tag, "_pc_ld"},  32'(pc_ld), 0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RESET_N  = 1'b0;
        run      = 1'b0;
        imem_ack = 1'b0;
        alu_done = 1'b0;
        #1;
        check_all_zero("reset");
        release_reset();
    endtask

    task automatic fetch(input logic [15:0] data, input int dly, input dec_exp_t e);
        run = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < dly; i++) begin
            chk("req_wait", 32'(imem_req), 1);
            @(posedge CLK);
            #1;
        end
        chk("req_ack", 32'(imem_req), 1);
        imem_ack  = 1'b1;
        imem_data = data;
        run       = 1'b0;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        chk("ir_latched", 32'(ir), 32'(data));
    endtask

    task automatic do_instr(input vec_t v);
        dec_exp_t e;
        e.e_pc_en = v.e_pc_en;
        e.e_ld_en = v.e_ld_en;
        e.e_ld    = v.e_ld;
        e.e_ill   = v.e_ill;
        e.e_ir    = v.data;
        flag_z = v.z;
        flag_c = v.c;
        fetch(v.data, v.ack_dly, e);
        @(posedge CLK);
        #1;
        if (v.nxt == NXT_ALU) begin
            chk("ex_alu_start", 32'(alu_start), 1);
            chk("ex_alu_op",    32'(alu_op), 32'(v.data[15:12]));
            alu_done = 1'b1;
            @(posedge CLK);
            #1;
            alu_done = 1'b0;
            for (int i = 0; i < v.alu_dly; i++) begin
                chk("wa_alu_start", 32'(alu_start), 0);
                chk("wa_alu_op",    32'(alu_op), 32'(v.data[15:12]));
                @(posedge CLK);
                #1;
            end
            chk("wa_alu_op_last", 32'(alu_op), 32'(v.data[15:12]));
            alu_done = 1'b1;
            @(posedge CLK);
            #1;
            alu_done = 1'b0;
            chk("post_alu_op",  32'(alu_op), 0);
            chk("post_alu_req", 32'(imem_req), 0);
            chk("post_alu_hlt", 32'(halted), 0);
        end else if (v.nxt == NXT_HALT) begin
            chk("hlt_halted", 32'(halted), 1);
            chk("hlt_req",    32'(imem_req), 0);
            chk("hlt_fault",  32'(fault), 0);
        end else begin
            chk("fetch_req",    32'(imem_req), 0);
            chk("fetch_halted", 32'(halted), 0);
            chk("fetch_alu_op", 32'(alu_op), 0);
            chk("fetch_fault",  32'(fault), 0);
        end
        flag_z = 1'b0;
        flag_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_exp_t e3;
        //          data     z     c    ack alu pc_en ld_en ld     ill   next
        vt[0]  = '{16'h0000, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 8'h00, 1'b0, NXT_FETCH};
        vt[1]  = '{16'h8042, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 8'h42, 1'b0, NXT_FETCH};
        vt[2]  = '{16'h9010, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 8'h00, 1'b0, NXT_FETCH};
        vt[3]  = '{16'h9010, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 8'h10, 1'b0, NXT_FETCH};
        vt[4]  = '{16'hA0FF, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 8'hFF, 1'b0, NXT_FETCH};
        vt[5]  = '{16'hA0FF, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 8'h00, 1'b0, NXT_FETCH};
        vt[6]  = '{16'h3000, 1'b0, 1'b0, 1, 4, 1'b1, 1'b0, 8'h00, 1'b0, NXT_ALU};
        vt[7]  = '{16'h7ABC, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 8'h00, 1'b0, NXT_ALU};
        vt[8]  = '{16'hC000, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 8'h00, 1'b1, NXT_FETCH};
        vt[9]  = '{16'hE055, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0, 8'h00, 1'b1, NXT_FETCH};
        vt[10] = '{16'hF000, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, NXT_HALT};
        vt[11] = '{16'h0000, 1'b0, 1'b0, MEM_TIMEOUT, 0, 1'b1, 1'b0, 8'h00, 1'b0, NXT_FETCH};
        vt[12] = '{16'h8AB0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 8'hB0, 1'b0, NXT_FETCH};

        #3;
        check_all_zero("por");
        release_reset();

        // run=0 keeps the FSM parked in FETCH
        for (int i = 0; i < 8; i++) begin
            chk("stall_req", 32'(imem_req), 0);
            @(posedge CLK);
            #1;
        end

        foreach (vt[i]) begin
            do_reset();
            do_instr(vt[i]);
        end

        // HALT ignores run and leaves only through async reset
        do_reset();
        do_instr(vt[10]);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            @(posedge CLK);
            #1;
            chk("hold_halted", 32'(halted), 1);
            chk("hold_req",    32'(imem_req), 0);
        end
        run = 1'b0;
        #2 RESET_N = 1'b0;
        #1 chk("hlt_async_clear", 32'(halted), 0);
        release_reset();

        // memory timeout: 16 WAIT_MEM cycles without ack
        do_reset();
        run = 1'b1;
        @(posedge CLK);
        #1;
        run = 1'b0;
        for (int i = 1; i <= MEM_TIMEOUT + 1; i++) begin
            chk("to_req",   32'(imem_req), 1);
            chk("to_fault", 32'(fault), 0);
            @(posedge CLK);
            #1;
        end
        chk("to_fault_set", 32'(fault), 1);
        chk("to_halted",    32'(halted), 1);
        chk("to_req_off",   32'(imem_req), 0);
        for (int i = 0; i < 5; i++) begin
            run = 1'b1;
            @(posedge CLK);
            #1;
            chk("to_fault_sticky", 32'({fault, halted}), 3);
        end
        run = 1'b0;
        #2 RESET_N = 1'b0;
        #1 chk("to_fault_clear", 32'({fault, halted}), 0);
        release_reset();

        // reset while waiting on the ALU abandons the operation immediately
        do_reset();
        e3.e_pc_en = 1'b1;
        e3.e_ld_en = 1'b0;
        e3.e_ld    = 8'h00;
        e3.e_ill   = 1'b0;
        e3.e_ir    = 16'h3000;
        fetch(16'h3000, 0, e3);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("mid_alu_op", 32'(alu_op), 3);
        #2 RESET_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        alu_done = 1'b1;
        release_reset();
        alu_done = 1'b0;
        chk("mid_after_req", 32'(imem_req), 0);
        chk("mid_after_op",  32'(alu_op), 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
